// File: rtl/dft_scan_unload_pkg.sv
// Shared types and constants for the DFT scan-chain unload block.
// Pulls parallel scan chains into 32-bit words and writes them to per-chain register files.
package dft_scan_unload_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned RF_DEPTH   = 64;
  localparam int unsigned MAX_SC_NBR = 16;
  localparam int unsigned MAX_SC_LEN = WORD_W * RF_DEPTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Number of packed words that one chain produces.
  function automatic int unsigned words_per_chain(input int unsigned sc_len);
    return sc_len / WORD_W;
  endfunction

endpackage

// File: rtl/dft_scan_unload_if.sv
// Register-file write bus that carries the unloaded chain words.
// It has one data slice, one address slice and one write enable per scan chain.
interface dft_scan_unload_if
  import dft_scan_unload_pkg::*;
#(
  parameter int unsigned P_SC_NBR = MAX_SC_NBR
);

  logic [WORD_W*P_SC_NBR-1:0] dft_output_data;
  logic [WORD_W*P_SC_NBR-1:0] dft_output_data_wraddr;
  logic [P_SC_NBR-1:0]        dft_wen;

  modport master (
    output dft_output_data,
    output dft_output_data_wraddr,
    output dft_wen
  );

  modport slave (
    input dft_output_data,
    input dft_output_data_wraddr,
    input dft_wen
  );

endinterface

// File: rtl/dft_scan_unload_scan_word_packer.sv
// Serial-in packer for one scan chain. Bits shift in at the MSB, so the first bit out of the chain becomes word bit 0.
// The next-state word is exported so that the parent can register a complete word on the final shift.
module scan_word_packer
  import dft_scan_unload_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              sin,
  output logic [WORD_W-1:0] word_next
);

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  always_comb begin
    word_next = {sin, word_q[WORD_W-1:1]};
    word_d    = shift_en ? word_next : word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/dft_scan_unload.sv
// DFT scan unload: performs one capture cycle and then unloads every chain in 32-bit words.
// It issues one register-file write per word on all chains in parallel.
module dft_scan_unload
  import dft_scan_unload_pkg::*;
#(
  parameter int unsigned P_SC_NBR   = MAX_SC_NBR,
  parameter int unsigned P_SC_LEN   = MAX_SC_LEN,
  parameter int unsigned P_RF_DEPTH = RF_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [P_SC_NBR-1:0] scan_out,
  output logic                scan_en,
  output logic                capture,
  output logic                busy,
  output logic                done,
  dft_scan_unload_if.master   wr_bus
);

  localparam int unsigned WORDS     = words_per_chain(P_SC_LEN);
  localparam logic [5:0]  LAST_WORD = 6'(WORDS - 1);
  localparam int unsigned BUS_W     = WORD_W * P_SC_NBR;

  state_e state_q, state_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [5:0] word_cnt_q, word_cnt_d;

  logic                scan_en_q, scan_en_d;
  logic                capture_q, capture_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [P_SC_NBR-1:0] wen_q, wen_d;
  logic [BUS_W-1:0]    data_q, data_d;
  logic [BUS_W-1:0]    wraddr_q, wraddr_d;

  logic [WORD_W-1:0]   word_next [P_SC_NBR];

  // Each packer shifts exactly when the registered scan_en is high, which keeps it in step with the chains.
  for (genvar i = 0; i < P_SC_NBR; i++) begin : g_chain
    scan_word_packer u_packer (
      .clk       (clk),
      .rst_n     (reset),
      .shift_en  (scan_en_q),
      .sin       (scan_out[i]),
      .word_next (word_next[i])
    );
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    if (abort) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (start) state_d = ST_CAPTURE;
        ST_CAPTURE: state_d = ST_SHIFT;
        ST_SHIFT: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) state_d = ST_WRITE;
        end
        ST_WRITE: begin
          if (word_cnt_q == LAST_WORD) begin
            state_d    = ST_DONE;
            word_cnt_d = '0;
          end else begin
            state_d    = ST_SHIFT;
            word_cnt_d = word_cnt_q + 6'd1;
          end
        end
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state. This registers them so that they line up with state_q.
  // The data register loads the word that the final shift completes.
  always_comb begin : out_next
    scan_en_d = (state_d == ST_SHIFT);
    capture_d = (state_d == ST_CAPTURE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    wen_d     = {P_SC_NBR{state_d == ST_WRITE}};
    data_d    = data_q;
    wraddr_d  = wraddr_q;
    if (state_d == ST_WRITE) begin
      for (int unsigned i = 0; i < P_SC_NBR; i++) begin
        data_d[WORD_W*i +: WORD_W]   = word_next[i];
        wraddr_d[WORD_W*i +: WORD_W] = 32'(P_RF_DEPTH * i) + 32'(word_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      scan_en_q  <= 1'b0;
      capture_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wen_q      <= '0;
      data_q     <= '0;
      wraddr_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      scan_en_q  <= scan_en_d;
      capture_q  <= capture_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wen_q      <= wen_d;
      data_q     <= data_d;
      wraddr_q   <= wraddr_d;
    end
  end

  assign scan_en                       = scan_en_q;
  assign capture                       = capture_q;
  assign busy                          = busy_q;
  assign done                          = done_q;
  assign wr_bus.dft_wen                = wen_q;
  assign wr_bus.dft_output_data        = data_q;
  assign wr_bus.dft_output_data_wraddr = wraddr_q;

endmodule
